// File: rtl/signed_sub_8bit_pkg.sv
// Purpose: shared width constants and the signed operand type for the subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package signed_sub_8bit_pkg;

    localparam int WIDTH    = 8;
    localparam int SIGN_BIT = WIDTH - 1;

    typedef logic signed [WIDTH-1:0] operand_t;

endpackage : signed_sub_8bit_pkg

// File: rtl/signed_sub_8bit_sub_bit_cell.sv
// Purpose: one full-adder stage of the subtract ripple chain (a + b_inv + ci).
// Latency: combinational, zero cycles.
// Backpressure: none; pure logic with no flow control.
//
// Ports:
//   a_i     - minuend bit
//   b_inv_i - inverted subtrahend bit
//   c_i     - carry in from the next lower stage
//   s_o     - sum bit
//   c_o     - carry out to the next higher stage
module sub_bit_cell (
    input  logic a_i,
    input  logic b_inv_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_inv_i ^ c_i;
    assign c_o = (a_i & b_inv_i) | (a_i & c_i) | (b_inv_i & c_i);

endmodule : sub_bit_cell

// File: rtl/signed_sub_8bit.sv
// Purpose: two's-complement A - B with add-style overflow, plus registered copies and a sticky overflow.
// Latency: result/overflow combinational; result_q/overflow_q/ovf_sticky one cycle.
// Backpressure: none; registers update every cycle with no enable.
//
// Ports:
//   clk        - rising-edge clock for the registered outputs
//   rst        - asynchronous active-high reset of the registered outputs
//   A, B       - signed minuend / subtrahend
//   result     - combinational A - B (wraps)
//   overflow   - combinational overflow of A + (-B) where -B is the WIDTH-bit negation
//   result_q   - result delayed one clock
//   overflow_q - overflow delayed one clock
//   sticky_clr - synchronous clear of ovf_sticky (loses to a simultaneous overflow)
//   ovf_sticky - latches any sampled overflow until cleared
module signed_sub_8bit
    import signed_sub_8bit_pkg::*;
#(
    parameter int WIDTH = signed_sub_8bit_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] result_q,
    output logic             overflow_q,
    input  logic             sticky_clr,
    output logic             ovf_sticky
);

    localparam int SB = WIDTH - 1;

    // ------------------------------------------------------------------
    // Ripple chain: A + ~B + 1
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             carry_unused;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sub_bit_cell u_cell (
            .a_i     (A[i]),
            .b_inv_i (~B[i]),
            .c_i     (carry[i]),
            .s_o     (sum[i]),
            .c_o     (carry[i+1])
        );
    end

    // The unsigned borrow is not part of this block's interface.
    assign carry_unused = carry[WIDTH];

    assign result = sum;

    // Sign of NB = ~B + 1. The +1 only ripples into the sign bit when the
    // low bits of B are all zero: that flips NB's sign back for B = 0 (NB = 0)
    // and keeps it set for B = most-negative (NB = B).
    logic nb_sign;
    assign nb_sign = ~B[SB] ^ (B[SB-1:0] == '0);

    // Add-overflow of A + NB: equal operand signs and a result sign that differs.
    // For B = most-negative this intentionally differs from true subtract overflow.
    assign overflow = (A[SB] == nb_sign) && (sum[SB] != A[SB]);

    // ------------------------------------------------------------------
    // Registered copies and sticky flag
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_d;
    logic             overflow_d;
    logic             sticky_d;
    logic [WIDTH-1:0] res_q;
    logic             ovf_q;
    logic             sticky_q;

    always_comb begin
        result_d   = result;
        overflow_d = overflow;
        sticky_d   = sticky_q;
        // Set has priority over clear so an overflow event is never dropped.
        if (overflow) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            res_q    <= result_d;
            ovf_q    <= overflow_d;
            sticky_q <= sticky_d;
        end
    end

    assign result_q   = res_q;
    assign overflow_q = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule : signed_sub_8bit

// File: tb/tb_signed_sub_8bit.sv
// Purpose: self-checking bench for signed_sub_8bit (tables, corner sweep, random vs. arithmetic model).
// Latency: checks combinational outputs same step, registered outputs one edge later.
// Backpressure: n/a.
module tb_signed_sub_8bit;
    import signed_sub_8bit_pkg::*;

    logic       clk;
    logic       rst;
    operand_t   a_s;
    operand_t   b_s;
    logic [7:0] result;
    logic       overflow;
    logic [7:0] result_q;
    logic       overflow_q;
    logic       sticky_clr;
    logic       ovf_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    signed_sub_8bit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (a_s),
        .B          (b_s),
        .result     (result),
        .overflow   (overflow),
        .result_q   (result_q),
        .overflow_q (overflow_q),
        .sticky_clr (sticky_clr),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic [7:0]        exp_r;
        logic              exp_o;
    } vec_t;

    // Arithmetic model: negate B as an 8-bit quantity (most-negative stays put),
    // add with unbounded integers, then wrap and range-check the sum.
    function automatic void model(input logic signed [7:0] a, input logic signed [7:0] b,
                                  output logic [7:0] r, output logic o);
        int nb;
        int s;
        nb = (b == -8'sd128) ? -128 : -int'(b);
        s  = int'(a) + nb;
        r  = s[7:0];
        o  = (s > 127) || (s < -128);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (A=%0d B=%0d)", name, act, exp, a_s, b_s);
    endtask

    vec_t tbl[9];
    logic signed [7:0] corners[9];
    logic [7:0] mr;
    logic       mo;
    logic       sticky_m;

    initial begin
        tbl[0] = '{ 8'sd127,  -8'sd1,   8'h80, 1'b1};
        tbl[1] = '{-8'sd128,   8'sd1,   8'h7F, 1'b1};
        tbl[2] = '{ 8'sd64,   -8'sd64,  8'h80, 1'b1};
        tbl[3] = '{-8'sd64,    8'sd64,  8'h80, 1'b0};
        tbl[4] = '{ 8'sd0,    -8'sd128, 8'h80, 1'b0};
        tbl[5] = '{ 8'sd127,  -8'sd128, 8'hFF, 1'b0};
        tbl[6] = '{-8'sd1,    -8'sd128, 8'h7F, 1'b1};
        tbl[7] = '{-8'sd128,  -8'sd128, 8'h00, 1'b1};
        tbl[8] = '{ 8'sd5,     8'sd3,   8'h02, 1'b0};
        corners = '{8'sd0, 8'sd1, -8'sd1, 8'sd127, -8'sd128, 8'sd126, -8'sd127, 8'sd64, -8'sd64};

        rst = 1'b1; a_s = '0; b_s = '0; sticky_clr = 1'b0;
        #2;
        check("reset_result_q",   32'(result_q),   32'h0);
        check("reset_overflow_q", 32'(overflow_q), 32'h0);
        check("reset_sticky",     32'(ovf_sticky), 32'h0);

        // Directed table, applied while reset is held: combinational path must ignore it.
        for (int i = 0; i < 9; i++) begin
            a_s = tbl[i].a; b_s = tbl[i].b;
            #1;
            check("tbl_result",   32'(result),   32'(tbl[i].exp_r));
            check("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_o));
        end

        // Corner sweep, 81 pairs, 5 ns settle each.
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                a_s = corners[i]; b_s = corners[j];
                #5;
                model(a_s, b_s, mr, mo);
                check("sweep_result",   32'(result),   32'(mr));
                check("sweep_overflow", 32'(overflow), 32'(mo));
            end
        end
        check("held_reset_result_q", 32'(result_q), 32'h0);

        // Registered latency: reset held two cycles, then first capture.
        @(negedge clk); a_s = '0; b_s = '0;
        repeat (2) @(negedge clk);
        a_s = 8'sd5; b_s = 8'sd3; rst = 1'b0;
        #1;
        check("lat_result_now",   32'(result),     32'h2);
        check("lat_result_q_pre", 32'(result_q),   32'h0);
        @(posedge clk); #1;
        check("lat_result_q",     32'(result_q),   32'h2);
        check("lat_overflow_q",   32'(overflow_q), 32'h0);

        // Sticky set, hold, set-beats-clear, then clear.
        @(negedge clk); a_s = 8'sd127; b_s = -8'sd1;
        @(posedge clk); #1;
        check("sticky_set",     32'(ovf_sticky), 32'h1);
        check("overflow_q_set", 32'(overflow_q), 32'h1);
        @(negedge clk); a_s = 8'sd1; b_s = 8'sd1;
        repeat (2) @(posedge clk); #1;
        check("sticky_hold",    32'(ovf_sticky), 32'h1);
        @(negedge clk); sticky_clr = 1'b1; a_s = 8'sd127; b_s = -8'sd1;
        @(posedge clk); #1;
        check("sticky_set_wins", 32'(ovf_sticky), 32'h1);
        @(negedge clk); a_s = 8'sd1; b_s = 8'sd1;
        @(posedge clk); #1;
        check("sticky_clear",   32'(ovf_sticky), 32'h0);
        @(negedge clk); sticky_clr = 1'b0;

        // Async reset between edges with live state.
        a_s = 8'sd127; b_s = -8'sd1;
        @(posedge clk); #2;
        check("pre_rst_result_q", 32'(result_q),   32'h80);
        check("pre_rst_sticky",   32'(ovf_sticky), 32'h1);
        rst = 1'b1;
        #1;
        check("arst_result_q",   32'(result_q),   32'h0);
        check("arst_overflow_q", 32'(overflow_q), 32'h0);
        check("arst_sticky",     32'(ovf_sticky), 32'h0);
        check("arst_result",     32'(result),     32'h80);
        check("arst_overflow",   32'(overflow),   32'h1);
        @(posedge clk); #1;
        check("arst_hold_result_q", 32'(result_q),   32'h0);
        check("arst_hold_sticky",   32'(ovf_sticky), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Randomized run against the arithmetic model, corners mixed in.
        sticky_m = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] er;
            logic       eo;
            @(negedge clk);
            a_s = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 8)] : operand_t'($urandom);
            b_s = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 8)] : operand_t'($urandom);
            sticky_clr = ($urandom_range(0, 3) == 0);
            #1;
            model(a_s, b_s, er, eo);
            check("rnd_result",   32'(result),   32'(er));
            check("rnd_overflow", 32'(overflow), 32'(eo));
            if (eo) sticky_m = 1'b1;
            else if (sticky_clr) sticky_m = 1'b0;
            @(posedge clk); #1;
            check("rnd_result_q",   32'(result_q),   32'(er));
            check("rnd_overflow_q", 32'(overflow_q), 32'(eo));
            check("rnd_sticky",     32'(ovf_sticky), 32'(sticky_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_signed_sub_8bit

// File: doc/signed_sub_8bit.md
Name: signed_sub_8bit

Overview:
- Two's-complement subtractor computing A - B with a signed-overflow flag.
- Datapath is purely combinational, so result and overflow settle with zero latency after inputs change.
- Adds a one-cycle registered copy of both outputs and a sticky overflow flag.
- Used as the signed subtract primitive in arithmetic datapaths; the registered and sticky outputs serve pipelined and status-collecting consumers.

Parameters:
- WIDTH, 8, operand/result width in bits; all behaviour below is written for 8 and generalises with 7 -> WIDTH-1.

Ports:
- clk  input  1  rising-edge clock for registered and sticky outputs
- rst  input  1  reset, asynchronous, active-high
- A  input  8  minuend, signed two's complement
- B  input  8  subtrahend, signed two's complement
- result  output  8  combinational A - B, signed
- overflow  output  1  combinational overflow flag, defined in Behaviour
- result_q  output  8  result registered on clk
- overflow_q  output  1  overflow registered on clk
- sticky_clr  input  1  synchronous clear of ovf_sticky
- ovf_sticky  output  1  set when overflow=1 is sampled; held until cleared

Behaviour:

Combinational path (no clock dependence; valid within the same delta/timestep after A/B change):
- NB = (~B + 1) mod 256, the 8-bit two's-complement negation of B. NB of -128 is -128.
- result = (A + NB) mod 256, bit-identical to 8-bit A - B with wrap-around.
  - Examples: 0 - (-128) = -128; 127 - (-1) = -128; -128 - 1 = 127.
- overflow = (A[7] == NB[7]) AND (result[7] != A[7]). This is the add-overflow of A + NB.
- When B = -128, the flag deliberately follows this formula, not the mathematical subtraction overflow:
  - A >= 0 gives overflow = 0 (e.g. 0 - (-128) -> result -128, overflow 0).
  - A < 0 gives overflow = 1 (e.g. -1 - (-128) -> result 127, overflow 1; -128 - (-128) -> result 0, overflow 1).
- result and overflow never depend on clk or rst, including while rst is asserted.
- No X propagation from registers into this path.

Registered path:
- Rising clk edge: result_q <= result, overflow_q <= overflow. Latency 1 cycle, updated every cycle, no enable.
- ovf_sticky next-state, evaluated in this order:
  - overflow = 1: ovf_sticky <= 1. Set wins over a simultaneous sticky_clr, so an event is never lost.
  - else sticky_clr = 1: ovf_sticky <= 0.
  - else: hold.
- rst asserted asynchronously (any time, including mid-operation) forces result_q = 0, overflow_q = 0, ovf_sticky = 0 immediately.
- These values hold while rst = 1.
- First capture is on the first rising clk edge after rst deasserts.

Decomposition:
- Shared package: WIDTH default constant, SIGN_BIT = WIDTH-1, signed operand typedef logic signed [WIDTH-1:0].
- One sub-module: sub_bit_cell, a full-adder cell taking a, b_inv, carry-in and giving sum, carry-out.
  - Instantiate WIDTH copies as a ripple chain with carry-in 1 to form A + ~B + 1.
  - overflow is taken from the sign bits per the formula above, not from behavioural arithmetic.

Test Plan:
- Combinational corner sweep over {0, 1, -1, 127, -128, 126, -127, 64, -64} for both A and B (81 pairs), 5 ns settle each -> result == 8-bit A - B and overflow == formula, 0 mismatches.
- A=127, B=-1 -> result -128 (0x80), overflow 1; A=-128, B=1 -> result 127, overflow 1; A=64, B=-64 -> result -128, overflow 1; A=-64, B=64 -> result -128, overflow 0.
- B=-128 quirk: A=0 -> result -128, overflow 0; A=127 -> result -1, overflow 0; A=-1 -> result 127, overflow 1; A=-128 -> result 0, overflow 1.
- Registered latency: hold rst 2 cycles, then A=5, B=3 -> result=2 immediately; result_q=2, overflow_q=0 after the next edge, and 0 before it.
- Sticky: A=127, B=-1 for one cycle -> ovf_sticky=1 and holds over later non-overflow inputs. Then sticky_clr=1 with overflow=1 -> stays 1; sticky_clr=1 with overflow=0 -> 0 next edge.
- Async reset mid-run: assert rst between clock edges while ovf_sticky=1 and result_q!=0 -> all registered outputs 0 immediately; combinational result/overflow unaffected.
